// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Carries the predictor decision for each fetched instruction through the
// IF_ID and ID_EX pipeline registers, resolves the real next PC in EX,
// and raises mispredict/flush with the redirect target in the same cycle.
// It also drives the predictor update bus and, optionally, two performance
// counters.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   IF_pc, IF_predict_taken,    fetch PC and the predictor's decision and
//   IF_predicted_pc             next-PC for it
//   stall                       load-use stall: hold IF_ID, bubble ID_EX
//   ID_is_branch/jal/jalr       decode of the instruction held in IF_ID
//   EX_branch_cond              compare result for the ID_EX instruction
//   EX_target                   ID_EX pc + imm (branch / JAL target)
//   EX_jalr_target              rs1 + imm for JALR (bit 0 is dropped)
//   mispredict, flush           EX next-PC differs from the prediction
//   redirect_pc                 correct next PC (valid while mispredict=1)
//   ID_EX_*                     predictor update bus
//   perf_branch_count,          resolved control instructions / mispredicts
//   perf_mispredict_count
//
// Configuration
//   BRANCH_PERF_COUNTER_EN      when defined, builds the two 32-bit wrapping
//                               performance counters; otherwise both perf
//                               outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_resolve_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IF_pc,
    input  logic        IF_predict_taken,
    input  logic [31:0] IF_predicted_pc,
    input  logic        stall,
    input  logic        ID_is_branch,
    input  logic        ID_is_jal,
    input  logic        ID_is_jalr,
    input  logic        EX_branch_cond,
    input  logic [31:0] EX_target,
    input  logic [31:0] EX_jalr_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] ID_EX_pc,
    output logic [31:0] ID_EX_branch_target,
    output logic        ID_EX_is_branch,
    output logic        ID_EX_is_jal,
    output logic        ID_EX_actual_branch_taken,
    output logic [31:0] perf_branch_count,
    output logic [31:0] perf_mispredict_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        predict_taken;
        logic [31:0] predicted_pc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        predict_taken;
        logic [31:0] predicted_pc;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
    } id_ex_t;

    if_id_t      if_id;
    id_ex_t      id_ex;

    logic        actual_taken;
    logic [31:0] pc_plus4;
    logic [31:0] actual_next;

    // The carried taken bit is not needed for resolution (the predicted PC
    // already encodes it) but stays in the entry for debug visibility.
    logic        unused_predict_taken;
    assign unused_predict_taken = id_ex.predict_taken;

    // -----------------------------------------------------------------------
    // Pipeline registers. Reset beats flush, flush beats stall. On a flush
    // only the valid bits are cleared; stale payload is harmless because
    // every consumer is qualified by valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id <= '0;
            id_ex <= '0;
        end else if (flush) begin
            if_id.valid <= 1'b0;
            id_ex.valid <= 1'b0;
        end else begin
            if (!stall) begin
                if_id.valid         <= 1'b1;
                if_id.pc            <= IF_pc;
                if_id.predict_taken <= IF_predict_taken;
                if_id.predicted_pc  <= IF_predicted_pc;
            end
            id_ex.valid         <= if_id.valid & ~stall;
            id_ex.pc            <= if_id.pc;
            id_ex.predict_taken <= if_id.predict_taken;
            id_ex.predicted_pc  <= if_id.predicted_pc;
            id_ex.is_branch     <= ID_is_branch;
            id_ex.is_jal        <= ID_is_jal;
            id_ex.is_jalr       <= ID_is_jalr;
        end
    end

    // -----------------------------------------------------------------------
    // EX-stage resolution
    // -----------------------------------------------------------------------
    always_comb begin
        actual_taken = id_ex.is_jal | id_ex.is_jalr |
                       (id_ex.is_branch & EX_branch_cond);
        pc_plus4     = id_ex.pc + 32'd4;
        if (id_ex.is_jalr)
            actual_next = {EX_jalr_target[31:1], 1'b0};
        else if (actual_taken)
            actual_next = EX_target;
        else
            actual_next = pc_plus4;
        mispredict = id_ex.valid & (id_ex.predicted_pc != actual_next);
    end

    assign flush       = mispredict;
    assign redirect_pc = actual_next;

    assign ID_EX_pc                  = id_ex.pc;
    assign ID_EX_branch_target       = EX_target;
    assign ID_EX_actual_branch_taken = actual_taken;
    assign ID_EX_is_branch           = id_ex.valid & id_ex.is_branch;
    assign ID_EX_is_jal              = id_ex.valid & id_ex.is_jal;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef BRANCH_PERF_COUNTER_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (id_ex.valid & (id_ex.is_branch | id_ex.is_jal | id_ex.is_jalr))
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict)
                mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    assign perf_branch_count     = branch_cnt;
    assign perf_mispredict_count = mispredict_cnt;
`else
    assign perf_branch_count     = '0;
    assign perf_mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed table-driven bench for branch_resolve_unit. Each record is one
// clock cycle: the IF/ID/EX inputs applied in that cycle and the EX-stage
// outputs expected in the same cycle. Hand-written sequences cover stall,
// flush-over-stall, reset-over-stall and the performance counters.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_pc;
    logic        IF_predict_taken;
    logic [31:0] IF_predicted_pc;
    logic        stall;
    logic        ID_is_branch;
    logic        ID_is_jal;
    logic        ID_is_jalr;
    logic        EX_branch_cond;
    logic [31:0] EX_target;
    logic [31:0] EX_jalr_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] ID_EX_pc;
    logic [31:0] ID_EX_branch_target;
    logic        ID_EX_is_branch;
    logic        ID_EX_is_jal;
    logic        ID_EX_actual_branch_taken;
    logic [31:0] perf_branch_count;
    logic [31:0] perf_mispredict_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk                       (clk),
        .reset                     (reset),
        .IF_pc                     (IF_pc),
        .IF_predict_taken          (IF_predict_taken),
        .IF_predicted_pc           (IF_predicted_pc),
        .stall                     (stall),
        .ID_is_branch              (ID_is_branch),
        .ID_is_jal                 (ID_is_jal),
        .ID_is_jalr                (ID_is_jalr),
        .EX_branch_cond            (EX_branch_cond),
        .EX_target                 (EX_target),
        .EX_jalr_target            (EX_jalr_target),
        .mispredict                (mispredict),
        .redirect_pc               (redirect_pc),
        .flush                     (flush),
        .ID_EX_pc                  (ID_EX_pc),
        .ID_EX_branch_target       (ID_EX_branch_target),
        .ID_EX_is_branch           (ID_EX_is_branch),
        .ID_EX_is_jal              (ID_EX_is_jal),
        .ID_EX_actual_branch_taken (ID_EX_actual_branch_taken),
        .perf_branch_count         (perf_branch_count),
        .perf_mispredict_count     (perf_mispredict_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ppc;
        logic        st;
        logic        b;
        logic        j;
        logic        jr;
        logic        cond;
        logic [31:0] tgt;
        logic [31:0] jtgt;
        logic        v;      // expected ID_EX valid this cycle
        logic        mp;
        logic [31:0] redir;
        logic        isb;
        logic        isj;
        logic        tk;
        logic [31:0] expc;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] pc, input logic pt, input logic [31:0] ppc, input logic st,
        input logic b, input logic j, input logic jr, input logic cond,
        input logic [31:0] tgt, input logic [31:0] jtgt,
        input logic v, input logic mp, input logic [31:0] redir,
        input logic isb, input logic isj, input logic tk, input logic [31:0] expc);
        vec_t r;
        r.pc = pc; r.pt = pt; r.ppc = ppc; r.st = st;
        r.b = b; r.j = j; r.jr = jr; r.cond = cond;
        r.tgt = tgt; r.jtgt = jtgt;
        r.v = v; r.mp = mp; r.redir = redir;
        r.isb = isb; r.isj = isj; r.tk = tk; r.expc = expc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        IF_pc            = r.pc;
        IF_predict_taken = r.pt;
        IF_predicted_pc  = r.ppc;
        stall            = r.st;
        ID_is_branch     = r.b;
        ID_is_jal        = r.j;
        ID_is_jalr       = r.jr;
        EX_branch_cond   = r.cond;
        EX_target        = r.tgt;
        EX_jalr_target   = r.jtgt;
    endtask

    // Apply one cycle of stimulus, check at the falling edge, then advance.
    task automatic run_row(input vec_t r, input string tag);
        drive(r);
        @(negedge clk);
        chk({tag, "_mispredict"}, {31'b0, mispredict}, {31'b0, r.mp});
        chk({tag, "_flush"}, {31'b0, flush}, {31'b0, r.mp});
        chk({tag, "_is_branch"}, {31'b0, ID_EX_is_branch}, {31'b0, r.isb});
        chk({tag, "_is_jal"}, {31'b0, ID_EX_is_jal}, {31'b0, r.isj});
        if (r.mp)
            chk({tag, "_redirect_pc"}, redirect_pc, r.redir);
        if (r.v) begin
            chk({tag, "_taken"}, {31'b0, ID_EX_actual_branch_taken}, {31'b0, r.tk});
            chk({tag, "_pc"}, ID_EX_pc, r.expc);
            chk({tag, "_target"}, ID_EX_branch_target, r.tgt);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[28];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          pc           pt ppc          st b  j  jr cd tgt          jtgt         v  mp redir        isb isj tk expc
        tbl[0]  = mk(32'h0,      0, 32'h4,       0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[1]  = mk(32'h4,      0, 32'h8,       0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[2]  = mk(32'h8,      0, 32'hC,       0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[3]  = mk(32'hC,      0, 32'h10,      0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h4);
        tbl[4]  = mk(32'h10,     0, 32'h14,      0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h8);
        tbl[5]  = mk(32'h14,     0, 32'h18,      0, 1, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'hC);
        // BEQ at 0x10 predicted not-taken, resolves taken to 0x40
        tbl[6]  = mk(32'h18,     0, 32'h1C,      0, 0, 0, 0, 1, 32'h40,      32'h0,       1, 1, 32'h40,      1, 0, 1, 32'h10);
        tbl[7]  = mk(32'h40,     0, 32'h44,      0, 1, 0, 0, 1, 32'h40,      32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[8]  = mk(32'h44,     0, 32'h48,      0, 0, 0, 0, 1, 32'h99,      32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[9]  = mk(32'h48,     0, 32'h4C,      0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h40);
        tbl[10] = mk(32'h20,     1, 32'h80,      0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h44);
        tbl[11] = mk(32'h80,     0, 32'h84,      0, 1, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h48);
        // BNE at 0x20 predicted taken to 0x80, resolves not-taken
        tbl[12] = mk(32'h84,     0, 32'h88,      0, 0, 0, 0, 0, 32'h80,      32'h0,       1, 1, 32'h24,      1, 0, 0, 32'h20);
        tbl[13] = mk(32'h24,     0, 32'h28,      0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[14] = mk(32'h30,     0, 32'h34,      0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[15] = mk(32'h34,     0, 32'h38,      0, 0, 0, 1, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h24);
        // JALR at 0x30 predicted 0x34, rs1+imm = 0x101 -> 0x100
        tbl[16] = mk(32'h38,     0, 32'h3C,      0, 0, 0, 0, 0, 32'h999,     32'h101,     1, 1, 32'h100,     0, 0, 1, 32'h30);
        tbl[17] = mk(32'h100,    0, 32'h104,     0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[18] = mk(32'h200,    1, 32'h300,     0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[19] = mk(32'h300,    0, 32'h304,     0, 0, 1, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h100);
        // JAL at 0x200 correctly predicted to 0x300
        tbl[20] = mk(32'h304,    0, 32'h308,     0, 0, 0, 0, 0, 32'h300,     32'h0,       1, 0, 32'h0,       0, 1, 1, 32'h200);
        tbl[21] = mk(32'hFFFFFFFC, 0, 32'h0,     0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h300);
        tbl[22] = mk(32'h0,      0, 32'h4,       0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h304);
        // pc+4 wraps 0xFFFFFFFC -> 0x0
        tbl[23] = mk(32'h4,      0, 32'h8,       0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'hFFFFFFFC);
        tbl[24] = mk(32'h500,    1, 32'h600,     0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h0);
        tbl[25] = mk(32'h600,    0, 32'h604,     0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 0, 32'h0,       0, 0, 0, 32'h4);
        // non-control instruction with a bogus taken prediction
        tbl[26] = mk(32'h604,    0, 32'h608,     0, 0, 0, 0, 0, 32'h0,       32'h0,       1, 1, 32'h504,     0, 0, 0, 32'h500);
        tbl[27] = mk(32'h608,    0, 32'h60C,     0, 0, 0, 0, 0, 32'h0,       32'h0,       0, 0, 32'h0,       0, 0, 0, 32'h0);

        // Reset held for two cycles
        drive(mk(32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mispredict", {31'b0, mispredict}, 32'h0);
        chk("reset_flush", {31'b0, flush}, 32'h0);
        chk("reset_is_branch", {31'b0, ID_EX_is_branch}, 32'h0);
        chk("reset_is_jal", {31'b0, ID_EX_is_jal}, 32'h0);
        chk("reset_perf_branch", perf_branch_count, 32'h0);
        chk("reset_perf_mispredict", perf_mispredict_count, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 28; i++)
            run_row(tbl[i], $sformatf("r%0d", i));

        // Stall: IF_ID held, ID_EX bubble; then stall coinciding with a mispredict
        run_row(mk(32'h700, 0, 32'h704, 0, 1, 0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,   0, 0, 0, 32'h0),   "s0");
        run_row(mk(32'h704, 0, 32'h708, 1, 0, 0, 0, 0, 32'h0,   32'h0, 1, 0, 32'h0,   1, 0, 0, 32'h608), "s1");
        run_row(mk(32'h704, 0, 32'h708, 0, 0, 0, 0, 0, 32'h0,   32'h0, 0, 0, 32'h0,   0, 0, 0, 32'h0),   "s2");
        run_row(mk(32'h708, 0, 32'h70C, 0, 1, 0, 0, 0, 32'h0,   32'h0, 1, 0, 32'h0,   0, 0, 0, 32'h700), "s3");
        run_row(mk(32'h900, 0, 32'h904, 1, 0, 0, 0, 1, 32'h800, 32'h0, 1, 1, 32'h800, 1, 0, 1, 32'h704), "s4");
        run_row(mk(32'h800, 0, 32'h804, 0, 1, 0, 0, 1, 32'h800, 32'h0, 0, 0, 32'h0,   0, 0, 0, 32'h0),   "s5");
        run_row(mk(32'h804, 0, 32'h808, 0, 0, 0, 0, 1, 32'h999, 32'h0, 0, 0, 32'h0,   0, 0, 0, 32'h0),   "s6");
        run_row(mk(32'h808, 0, 32'h80C, 0, 0, 0, 0, 0, 32'h0,   32'h0, 1, 0, 32'h0,   0, 0, 0, 32'h800), "s7");

        // Reset overriding stall with entries in flight
        drive(mk(32'h900, 0, 32'h904, 1, 1, 0, 0, 1, 32'h999, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Three control instructions, one mispredicted
        run_row(mk(32'h1000, 1, 32'h1100, 0, 0, 0, 0, 0, 32'h0,    32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0),    "q0");
        run_row(mk(32'h1100, 0, 32'h1104, 0, 1, 0, 0, 0, 32'h0,    32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0),    "q1");
        run_row(mk(32'h1104, 0, 32'h1108, 0, 0, 1, 0, 1, 32'h1100, 32'h0, 1, 0, 32'h0,    1, 0, 1, 32'h1000), "q2");
        run_row(mk(32'h1108, 0, 32'h110C, 0, 1, 0, 0, 0, 32'h1104, 32'h0, 1, 0, 32'h0,    0, 1, 1, 32'h1100), "q3");
        run_row(mk(32'h110C, 0, 32'h1110, 0, 0, 0, 0, 1, 32'h2000, 32'h0, 1, 1, 32'h2000, 1, 0, 1, 32'h1104), "q4");
        run_row(mk(32'h2000, 0, 32'h2004, 0, 0, 0, 0, 0, 32'h0,    32'h0, 0, 0, 32'h0,    0, 0, 0, 32'h0),    "q5");

`ifdef BRANCH_PERF_COUNTER_EN
        chk("perf_branch_count", perf_branch_count, 32'd3);
        chk("perf_mispredict_count", perf_mispredict_count, 32'd1);
`else
        chk("perf_branch_count", perf_branch_count, 32'd0);
        chk("perf_mispredict_count", perf_mispredict_count, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: IF_pc  input  32  PC of the instruction being fetched.
REQ-004 SHALL have port: IF_predict_taken  input  1  predictor taken decision for IF_pc.
REQ-005 SHALL have port: IF_predicted_pc  input  32  predictor next-PC (BTB target or IF_pc+4).
REQ-006 SHALL have port: stall  input  1  load-use stall: hold IF_ID, inject bubble into ID_EX.
REQ-007 SHALL have port: ID_is_branch / ID_is_jal / ID_is_jalr  input  1 each  decode of the IF_ID instruction.
REQ-008 SHALL have port: EX_branch_cond  input  1  ALU compare result for the ID_EX instruction.
REQ-009 SHALL have port: EX_target  input  32  ID_EX pc + imm (branch/JAL target).
REQ-010 SHALL have port: EX_jalr_target  input  32  rs1 + imm for JALR.
REQ-011 SHALL have port: mispredict  output  1  EX-stage next-PC differs from the carried prediction.
REQ-012 SHALL have port: redirect_pc  output  32  correct next PC; meaningful only while mispredict=1.
REQ-013 SHALL have port: flush  output  1  kill IF_ID and ID_EX contents at the next posedge.
REQ-014 SHALL have ports: ID_EX_pc  output 32, ID_EX_branch_target  output 32, ID_EX_is_branch  output 1, ID_EX_is_jal  output 1, ID_EX_actual_branch_taken  output 1 -- predictor update bus.
REQ-015 SHALL have ports: perf_branch_count  output 32, perf_mispredict_count  output 32.

Function
REQ-016 SHALL register an IF_ID entry {valid, pc, predict_taken, predicted_pc} from IF inputs each posedge when stall=0 and flush=0; valid=1 on capture.
REQ-017 SHALL hold the IF_ID entry unchanged when stall=1 and flush=0.
REQ-018 SHALL register an ID_EX entry {valid, pc, predict_taken, predicted_pc, is_branch, is_jal, is_jalr} from IF_ID plus ID decode each posedge; valid=0 (bubble) when stall=1.
REQ-019 SHALL clear both valid bits at the posedge where flush=1; flush SHALL take priority over stall.
REQ-020 SHALL compute actual_taken = is_jal | is_jalr | (is_branch & EX_branch_cond) combinationally from the ID_EX entry.
REQ-021 SHALL compute actual_next = is_jalr ? {EX_jalr_target[31:1],1'b0} : actual_taken ? EX_target : pc+4 (32-bit wrap-around, no overflow flag).
REQ-022 SHALL assert mispredict = ID_EX.valid & (ID_EX.predicted_pc != actual_next), for control and non-control instructions alike, combinationally in the same cycle.
REQ-023 SHALL drive flush = mispredict and redirect_pc = actual_next; zero-cycle latency from ID_EX entry to redirect.
REQ-024 SHALL drive ID_EX_pc, ID_EX_branch_target (EX_target), ID_EX_actual_branch_taken from the EX stage; ID_EX_is_branch / ID_EX_is_jal SHALL be gated by ID_EX.valid; JALR SHALL NOT appear as is_jal.
REQ-025 SHALL guarantee at most one predictor update per valid ID_EX entry; bubbles produce no update.
REQ-026 SHALL treat a mispredict coinciding with stall=1 as a flush: IF_ID not held, both entries invalidated.

Reset
REQ-027 SHALL, while reset=1 at posedge, clear IF_ID.valid, ID_EX.valid, all carried fields and both perf counters to 0.
REQ-028 SHALL, after reset, present mispredict=0, flush=0, ID_EX_is_branch=0, ID_EX_is_jal=0 until a valid entry reaches ID_EX (two posedges minimum).
REQ-029 SHALL let reset override flush and stall in the same cycle, discarding any in-flight entries.

Configuration
REQ-030 SHALL, when BRANCH_PERF_COUNTER_EN is defined, increment perf_branch_count on each posedge with a valid ID_EX branch/JAL/JALR, and perf_mispredict_count on each posedge with mispredict=1, both wrapping 0xFFFFFFFF->0.
REQ-031 SHALL, when BRANCH_PERF_COUNTER_EN is undefined, implement no counter registers and tie both perf outputs to 32'h0.

Verification
REQ-032 SHALL cover: reset held 2 cycles, then non-control stream IF_pc=0x0,0x4,... with predicted_pc=pc+4 -> mispredict=0 throughout, no updates.
REQ-033 SHALL cover: BEQ at 0x10, predicted not-taken (0x14), EX_branch_cond=1, EX_target=0x40 -> mispredict=1, redirect_pc=0x40, flush=1, ID_EX_actual_branch_taken=1, both valids 0 next cycle.
REQ-034 SHALL cover: BNE at 0x20 predicted taken to 0x80, EX_branch_cond=0 -> mispredict=1, redirect_pc=0x24.
REQ-035 SHALL cover: JALR at 0x30 predicted 0x34, EX_jalr_target=0x101 -> redirect_pc=0x100, ID_EX_is_jal=0.
REQ-036 SHALL cover: stall=1 coincident with a mispredicting branch in ID_EX -> flush wins, IF_ID not held, ID_EX bubble next cycle.
REQ-037 SHALL cover (BRANCH_PERF_COUNTER_EN defined): 3 branches, 1 mispredicted -> perf_branch_count=3, perf_mispredict_count=1; undefined -> both read 0.
